rad_wb_io_regs: RTL and testbench
=================================

# rad_wb_io_regs

Wishbone-slave register block in the user-project area. It exposes a 6-bit status field and a 2-bit flag field on dedicated user I/O pads, plus a scratch register, an ID register and an error counter. Register state is optionally triplicated (TMR) with majority voting and per-cycle scrubbing. Firmware drives progress codes through it, and the off-chip bench monitors those codes on the pads.

## Interface
- BASE_ADDR, 32'h3000_0000, Wishbone base address; decode compares bits [31:8].
- ID_VALUE, 32'h5248_0001, read-only ID register contents.
- wb_clk_i  in  1  Wishbone clock; all state on the rising edge.
- wb_rst_ni  in  1  Reset, asynchronous, active-low.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone classic control.
- wbs_sel_i  in  4  Byte enables.
- wbs_adr_i  in  32  Byte address.
- wbs_dat_i  in  32  Write data.
- wbs_ack_o  out  1  Acknowledge.
- wbs_dat_o  out  32  Read data.
- io_out  out  38  Pad outputs: [25:20]=STATUS, [37:36]=FLAGS, all other bits 0.
- io_oeb  out  38  Active-low output enable: 0 on bits 20–25 and 36–37, 1 elsewhere (constant).

## Operation
- Register map (offset = adr[7:2]×4):
  - 0x00 STATUS [5:0] R/W.
  - 0x04 FLAGS [1:0] R/W.
  - 0x08 SCRATCH [31:0] R/W.
  - 0x0C ID, read-only.
  - 0x10 ERR_COUNT [15:0], read-only; write of any value clears it.
  - 0x14 INJECT, write-only; reads 0.
- Unused upper bits read 0.
- Writes honour wbs_sel_i per byte.
- Unmapped offset, or a BASE_ADDR mismatch with cyc&stb: acknowledge, read 0, write ignored.
- INJECT write: wdata[5:0] is XORed into STATUS storage (copy A only when TMR is enabled).
- ERR_COUNT increments by 1 on each cycle where any register's three copies disagree. It saturates at 0xFFFF.
- Reset values:
  - STATUS 0, FLAGS 0, SCRATCH 0, ERR_COUNT 0.
  - wbs_ack_o 0, wbs_dat_o 0, io_out 0.

## Timing
- Request = cyc & stb & !ack.
- wbs_ack_o is registered: high exactly one cycle, on the edge after the request is sampled, then low for at least one cycle.
- A back-to-back held stb therefore gets an ack every second cycle.
- Write data is committed on the same edge that raises ack. io_out reflects the new value from that edge.
- wbs_dat_o is registered and valid while ack is high. It holds 0 otherwise.
- Reset asserted mid-transaction: ack drops immediately and the write is lost. After release the master must reissue.
- A clear of ERR_COUNT coinciding with an increment: the clear wins.
- An INJECT write coinciding with scrub: injection lands at the ack edge, and the scrub corrects it on the following edge.

## Configuration
- WB_TMR_EN defined:
  - STATUS, FLAGS and SCRATCH are each held as three copies.
  - Outputs and reads use the bitwise majority vote.
  - Every cycle, all copies are rewritten with the voted value (scrub).
  - ERR_COUNT counts mismatch cycles.
- WB_TMR_EN undefined:
  - Single copy per register; no voter.
  - ERR_COUNT is constant 0 and its clear is a no-op.
  - An INJECT flip persists until overwritten.

## Structure
- Package rad_wb_pkg holds:
  - the register offset constants, field widths (STATUS_W=6, FLAGS_W=2, ERRCNT_W=16);
  - the pad bit positions (STATUS_LSB=20, FLAGS_LSB=36).
- Sub-module tmr_reg (parameter WIDTH):
  - ports clk, rst_n, we, per-byte write mask, d, inj, q, mismatch;
  - implements either the triplicated-register or single-register variant under WB_TMR_EN.
  - Instantiated once each for STATUS, FLAGS and SCRATCH.

## Test plan
- Reset then read all registers:
  - 0x00/0x04/0x08/0x10 read 0 and 0x0C reads 0x5248_0001;
  - io_out==0;
  - io_oeb[25:20]==0, io_oeb[37:36]==0, all other bits 1.
- Write STATUS sequence 0, 1, 3, 2 interleaved with FLAGS 1 then 0:
  - io_out[25:20] and io_out[37:36] follow each value at the ack edge;
  - each ack is exactly one cycle wide.
- SCRATCH write 0xDEADBEEF with sel=4'b0101, starting from 0:
  - read returns 0x00AD00EF.
- Access to BASE_ADDR+0x40 and to 0x3100_0000:
  - both acked, read 0, no register changes.
- With WB_TMR_EN: write STATUS=0x05, then INJECT=0x3F:
  - STATUS reads 0x05 and io_out[25:20] never deviates from 0x05;
  - ERR_COUNT==1; writing ERR_COUNT returns it to 0.
- Without WB_TMR_EN, same stimulus:
  - STATUS reads 0x3A;
  - ERR_COUNT stays 0.

Source files
------------

// File: rtl/rad_wb_io_regs_pkg.sv
// Shared constants for the rad_wb_io_regs Wishbone register block:
// register offsets, field widths and pad bit positions.
package rad_wb_pkg;

    localparam int unsigned STATUS_W   = 6;
    localparam int unsigned FLAGS_W    = 2;
    localparam int unsigned ERRCNT_W   = 16;
    localparam int unsigned STATUS_LSB = 20;
    localparam int unsigned FLAGS_LSB  = 36;
    localparam int unsigned IO_W       = 38;

    localparam logic [7:0] OFF_STATUS  = 8'h00;
    localparam logic [7:0] OFF_FLAGS   = 8'h04;
    localparam logic [7:0] OFF_SCRATCH = 8'h08;
    localparam logic [7:0] OFF_ID      = 8'h0C;
    localparam logic [7:0] OFF_ERRCNT  = 8'h10;
    localparam logic [7:0] OFF_INJECT  = 8'h14;

    typedef enum logic [2:0] {
        SEL_STATUS,
        SEL_FLAGS,
        SEL_SCRATCH,
        SEL_ID,
        SEL_ERRCNT,
        SEL_INJECT,
        SEL_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode_offset(input logic [5:0] word);
        logic [7:0] off;
        off = {word, 2'b00};
        case (off)
            OFF_STATUS:  return SEL_STATUS;
            OFF_FLAGS:   return SEL_FLAGS;
            OFF_SCRATCH: return SEL_SCRATCH;
            OFF_ID:      return SEL_ID;
            OFF_ERRCNT:  return SEL_ERRCNT;
            OFF_INJECT:  return SEL_INJECT;
            default:     return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rad_wb_io_regs_if.sv
// Wishbone classic slave bus bundle for rad_wb_io_regs.
interface rad_wb_io_regs_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/rad_wb_io_regs_tmr_reg.sv
// Byte-maskable register, triplicated with majority vote and per-cycle scrub
// when WB_TMR_EN is defined, otherwise a single plain copy.
module tmr_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [(WIDTH+7)/8-1:0]     be,
    input  logic [WIDTH-1:0]           d,
    input  logic [WIDTH-1:0]           inj,
    output logic [WIDTH-1:0]           q,
    output logic                       mismatch
);

    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;

    always_comb begin
        wmask = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            wmask[i] = be[i/8];
        end
    end

    always_comb begin
        nxt = cur;
        if (we) begin
            nxt = (cur & ~wmask) | (d & wmask);
        end
    end

`ifdef WB_TMR_EN
    logic [WIDTH-1:0] copy_a, copy_b, copy_c;

    assign cur      = (copy_a & copy_b) | (copy_a & copy_c) | (copy_b & copy_c);
    assign mismatch = (copy_a != copy_b) || (copy_a != copy_c);

    // Every copy is rewritten from the vote each cycle; injection hits copy A only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            copy_a <= '0;
            copy_b <= '0;
            copy_c <= '0;
        end else begin
            copy_a <= nxt ^ inj;
            copy_b <= nxt;
            copy_c <= nxt;
        end
    end
`else
    logic [WIDTH-1:0] copy_a;

    assign cur      = copy_a;
    assign mismatch = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            copy_a <= '0;
        end else begin
            copy_a <= nxt ^ inj;
        end
    end
`endif

    assign q = cur;

endmodule

// File: rtl/rad_wb_io_regs.sv
// Wishbone register block driving STATUS/FLAGS onto user I/O pads.
// Define WB_TMR_EN to triplicate STATUS, FLAGS and SCRATCH with scrubbing.
module rad_wb_io_regs
    import rad_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ID_VALUE  = 32'h5248_0001
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    rad_wb_io_regs_if.slave      wbs,
    output logic [IO_W-1:0]      io_out,
    output logic [IO_W-1:0]      io_oeb
);

    logic                 req;
    logic                 wr;
    logic                 hit;
    reg_sel_e             rsel;
    logic [31:0]          rdata;
    logic [STATUS_W-1:0]  status_q;
    logic [FLAGS_W-1:0]   flags_q;
    logic [31:0]          scratch_q;
    logic [STATUS_W-1:0]  status_inj;
    logic [ERRCNT_W-1:0]  errcnt_q;
    logic                 mm_status, mm_flags, mm_scratch;

    assign req  = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~wbs.wbs_ack_o;
    assign wr   = req & wbs.wbs_we_i;
    assign hit  = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign rsel = hit ? decode_offset(wbs.wbs_adr_i[7:2]) : SEL_NONE;

    assign status_inj = (wr && rsel == SEL_INJECT && wbs.wbs_sel_i[0])
                        ? wbs.wbs_dat_i[STATUS_W-1:0] : '0;

    tmr_reg #(.WIDTH(STATUS_W)) u_status (
        .clk(wb_clk_i), .rst_n(wb_rst_ni),
        .we(wr && rsel == SEL_STATUS), .be(wbs.wbs_sel_i[0:0]),
        .d(wbs.wbs_dat_i[STATUS_W-1:0]), .inj(status_inj),
        .q(status_q), .mismatch(mm_status)
    );

    tmr_reg #(.WIDTH(FLAGS_W)) u_flags (
        .clk(wb_clk_i), .rst_n(wb_rst_ni),
        .we(wr && rsel == SEL_FLAGS), .be(wbs.wbs_sel_i[0:0]),
        .d(wbs.wbs_dat_i[FLAGS_W-1:0]), .inj('0),
        .q(flags_q), .mismatch(mm_flags)
    );

    tmr_reg #(.WIDTH(32)) u_scratch (
        .clk(wb_clk_i), .rst_n(wb_rst_ni),
        .we(wr && rsel == SEL_SCRATCH), .be(wbs.wbs_sel_i),
        .d(wbs.wbs_dat_i), .inj('0),
        .q(scratch_q), .mismatch(mm_scratch)
    );

    // Clear has priority over a concurrent mismatch increment.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            errcnt_q <= '0;
        end else if (wr && rsel == SEL_ERRCNT) begin
            errcnt_q <= '0;
        end else if ((mm_status || mm_flags || mm_scratch) && errcnt_q != '1) begin
            errcnt_q <= errcnt_q + 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        case (rsel)
            SEL_STATUS:  rdata[STATUS_W-1:0] = status_q;
            SEL_FLAGS:   rdata[FLAGS_W-1:0]  = flags_q;
            SEL_SCRATCH: rdata               = scratch_q;
            SEL_ID:      rdata               = ID_VALUE;
            SEL_ERRCNT:  rdata[ERRCNT_W-1:0] = errcnt_q;
            default:     rdata               = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_dat_o <= '0;
        end else begin
            wbs.wbs_ack_o <= req;
            wbs.wbs_dat_o <= (req && !wbs.wbs_we_i) ? rdata : '0;
        end
    end

    always_comb begin
        io_out = '0;
        io_out[STATUS_LSB +: STATUS_W] = status_q;
        io_out[FLAGS_LSB  +: FLAGS_W]  = flags_q;
        io_oeb = '1;
        io_oeb[STATUS_LSB +: STATUS_W] = '0;
        io_oeb[FLAGS_LSB  +: FLAGS_W]  = '0;
    end

endmodule

// File: tb/tb_rad_wb_io_regs.sv
// Directed self-checking bench for rad_wb_io_regs (expectations follow WB_TMR_EN).
module tb_rad_wb_io_regs;

    logic        clk;
    logic        rst_n;
    logic [37:0] io_out;
    logic [37:0] io_oeb;
    int          checks;
    int          failures;

    rad_wb_io_regs_if wb ();

    rad_wb_io_regs #(
        .BASE_ADDR(32'h3000_0000),
        .ID_VALUE (32'h5248_0001)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wbs      (wb),
        .io_out   (io_out),
        .io_oeb   (io_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] pads(input logic [5:0] s, input logic [1:0] f);
        logic [37:0] v;
        v = '0;
        v[25:20] = s;
        v[37:36] = f;
        return v;
    endfunction

    task automatic xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                        input logic we, output logic [31:0] rd, output logic [37:0] io);
        int unsigned n;
        n = 0;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = dat;
        wb.wbs_sel_i = sel;
        wb.wbs_we_i  = we;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wb.wbs_ack_o && n < 8);
        check("ack_seen", {63'd0, wb.wbs_ack_o}, 64'd1);
        rd = wb.wbs_dat_o;
        io = io_out;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        @(posedge clk);
        #1;
        check("ack_one_cycle", {63'd0, wb.wbs_ack_o}, 64'd0);
        check("dat_idle_zero", {32'd0, wb.wbs_dat_o}, 64'd0);
    endtask

    logic [31:0] rd;
    logic [37:0] io;
    logic [5:0]  stat_m;
    logic [1:0]  flag_m;
    int          acks;

    initial begin
        checks   = 0;
        failures = 0;
        stat_m   = '0;
        flag_m   = '0;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = '0;
        wb.wbs_adr_i = '0;
        wb.wbs_dat_i = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {63'd0, wb.wbs_ack_o}, 64'd0);
        check("rst_dat", {32'd0, wb.wbs_dat_o}, 64'd0);
        check("rst_io_out", {26'd0, io_out}, 64'd0);
        check("io_oeb", {26'd0, io_oeb}, 64'h0F_FC0F_FFFF);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        xfer(32'h3000_0000, 0, 4'hF, 1'b0, rd, io); check("rd_status_rst", {32'd0, rd}, 64'd0);
        xfer(32'h3000_0004, 0, 4'hF, 1'b0, rd, io); check("rd_flags_rst", {32'd0, rd}, 64'd0);
        xfer(32'h3000_0008, 0, 4'hF, 1'b0, rd, io); check("rd_scratch_rst", {32'd0, rd}, 64'd0);
        xfer(32'h3000_000C, 0, 4'hF, 1'b0, rd, io); check("rd_id", {32'd0, rd}, 64'h5248_0001);
        xfer(32'h3000_0010, 0, 4'hF, 1'b0, rd, io); check("rd_errcnt_rst", {32'd0, rd}, 64'd0);
        xfer(32'h3000_0014, 0, 4'hF, 1'b0, rd, io); check("rd_inject", {32'd0, rd}, 64'd0);

        // Progress code sequence: pads must follow each write at its ack edge.
        stat_m = 6'd0; xfer(32'h3000_0000, 32'd0, 4'hF, 1'b1, rd, io);
        check("pads_s0", {26'd0, io}, {26'd0, pads(stat_m, flag_m)});
        flag_m = 2'd1; xfer(32'h3000_0004, 32'd1, 4'hF, 1'b1, rd, io);
        check("pads_f1", {26'd0, io}, {26'd0, pads(stat_m, flag_m)});
        stat_m = 6'd1; xfer(32'h3000_0000, 32'd1, 4'hF, 1'b1, rd, io);
        check("pads_s1", {26'd0, io}, {26'd0, pads(stat_m, flag_m)});
        stat_m = 6'd3; xfer(32'h3000_0000, 32'd3, 4'hF, 1'b1, rd, io);
        check("pads_s3", {26'd0, io}, {26'd0, pads(stat_m, flag_m)});
        flag_m = 2'd0; xfer(32'h3000_0004, 32'd0, 4'hF, 1'b1, rd, io);
        check("pads_f0", {26'd0, io}, {26'd0, pads(stat_m, flag_m)});
        stat_m = 6'd2; xfer(32'h3000_0000, 32'hFFFF_FF02, 4'hF, 1'b1, rd, io);
        check("pads_s2", {26'd0, io}, {26'd0, pads(stat_m, flag_m)});
        xfer(32'h3000_0000, 0, 4'hF, 1'b0, rd, io); check("rd_status_2", {32'd0, rd}, 64'd2);
        // sel[0] clear: STATUS must not change.
        xfer(32'h3000_0000, 32'd9, 4'hE, 1'b1, rd, io);
        check("status_sel_masked", {26'd0, io}, {26'd0, pads(6'd2, 2'd0)});

        xfer(32'h3000_0008, 32'hDEAD_BEEF, 4'b0101, 1'b1, rd, io);
        xfer(32'h3000_0008, 0, 4'hF, 1'b0, rd, io); check("scratch_bytes", {32'd0, rd}, 64'h00AD_00EF);

        // Unmapped offset and foreign base: acked, read 0, no side effects.
        xfer(32'h3000_0040, 32'hFFFF_FFFF, 4'hF, 1'b1, rd, io);
        xfer(32'h3000_0040, 0, 4'hF, 1'b0, rd, io); check("rd_unmapped", {32'd0, rd}, 64'd0);
        xfer(32'h3100_0000, 32'h0000_003F, 4'hF, 1'b1, rd, io);
        check("foreign_wr_pads", {26'd0, io}, {26'd0, pads(6'd2, 2'd0)});
        xfer(32'h3100_0008, 0, 4'hF, 1'b0, rd, io); check("rd_foreign", {32'd0, rd}, 64'd0);
        xfer(32'h3000_0008, 0, 4'hF, 1'b0, rd, io); check("scratch_kept", {32'd0, rd}, 64'h00AD_00EF);

        // Held strobe: ack toggles, one pulse every second cycle.
        wb.wbs_adr_i = 32'h3000_000C;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        acks = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (wb.wbs_ack_o) acks++;
        end
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        check("held_stb_acks", 64'(acks), 64'd2);
        @(posedge clk);
        #1;

        // Upset injection on STATUS.
        xfer(32'h3000_0000, 32'h05, 4'hF, 1'b1, rd, io);
        xfer(32'h3000_0014, 32'h3F, 4'hF, 1'b1, rd, io);
`ifdef WB_TMR_EN
        check("inj_pads_ack", {58'd0, io[25:20]}, 64'h05);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("inj_pads_hold", {58'd0, io_out[25:20]}, 64'h05);
        end
        xfer(32'h3000_0000, 0, 4'hF, 1'b0, rd, io); check("inj_status", {32'd0, rd}, 64'h05);
        xfer(32'h3000_0010, 0, 4'hF, 1'b0, rd, io); check("errcnt_one", {32'd0, rd}, 64'd1);
`else
        check("inj_pads_ack", {58'd0, io[25:20]}, 64'h3A);
        xfer(32'h3000_0000, 0, 4'hF, 1'b0, rd, io); check("inj_status", {32'd0, rd}, 64'h3A);
        xfer(32'h3000_0010, 0, 4'hF, 1'b0, rd, io); check("errcnt_zero", {32'd0, rd}, 64'd0);
`endif
        xfer(32'h3000_0010, 32'h1234, 4'hF, 1'b1, rd, io);
        xfer(32'h3000_0010, 0, 4'hF, 1'b0, rd, io); check("errcnt_cleared", {32'd0, rd}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
